pe_feeder: RTL and testbench

//  Transmit side of the PE load interface: drives filter_enable/filter and ifmap_enable/ifmap into one PE row.

---
 rtl/pe_pkg.sv | 20 ++
 rtl/pe_feeder.sv | 152 +++++++++++++++
 tb/tb_pe_feeder.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE load path: FSM state and load-phase encodings,
// plus default data/RF widths used by pe_feeder and the PE array top.
package pe_pkg;

  localparam int BITWIDTH_DEF      = 16;
  localparam int RF_ADDR_WIDTH_DEF = 3;
  localparam int ROW_LEN_DEF       = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_PE = 2'd2
  } state_t;

  typedef enum logic {
    FILTER = 1'b0,
    IFMAP  = 1'b1
  } phase_t;

endpackage

// File: rtl/pe_feeder.sv
// pe_feeder: transmit side of the PE load interface.
// Pulls filter and ifmap words from two upstream valid/ready streams,
// interleaves them F,I,F,I,... onto a PE row's shared enable/data buses,
// then waits for pe_ready before signalling done.
//
// Optional feature: define PE_FEEDER_FILTER_REUSE_EN to add the reuse_filter
// input; a pass started with reuse_filter=1 loads ifmap words only.
//
// Handshake: a word transfers on a rising clk edge where *_in_valid and
// *_in_ready are both high. *_in_ready depends only on registered state/phase,
// never on *_in_valid, so upstream may hold or drop valid at will.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int BITWIDTH      = BITWIDTH_DEF,
  parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
  parameter int ROW_LEN       = ROW_LEN_DEF
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
`ifdef PE_FEEDER_FILTER_REUSE_EN
  input  logic                reuse_filter,
`endif
  input  logic                filter_in_valid,
  input  logic [BITWIDTH-1:0] filter_in,
  output logic                filter_in_ready,
  input  logic                ifmap_in_valid,
  input  logic [BITWIDTH-1:0] ifmap_in,
  output logic                ifmap_in_ready,
  input  logic                pe_ready,
  output logic                filter_enable,
  output logic [BITWIDTH-1:0] filter,
  output logic                ifmap_enable,
  output logic [BITWIDTH-1:0] ifmap,
  output logic                busy,
  output logic                done,
  output state_t              state_dbg
);

  localparam int CW = $clog2(ROW_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(ROW_LEN - 1);

  // A pass longer than the PE register file cannot be stored.
  if (ROW_LEN < 1 || ROW_LEN > (1 << RF_ADDR_WIDTH)) begin : g_bad_row_len
    $error("pe_feeder: ROW_LEN must be in 1..2**RF_ADDR_WIDTH");
  end

  state_t                state, state_n;
  phase_t                phase, phase_n;
  logic [CW-1:0]         count, count_n;
  logic [BITWIDTH-1:0]   filter_n, ifmap_n;
  logic                  filter_enable_n, ifmap_enable_n, done_n;
  logic                  reuse_q, reuse_n;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Ready comes from state/phase only; both are low outside LOAD.
  always_comb begin
    filter_in_ready = (state == LOAD) && (phase == FILTER);
    ifmap_in_ready  = (state == LOAD) && (phase == IFMAP);
  end

  // Next-state, counter and output-register values.
  always_comb begin
    state_n         = state;
    phase_n         = phase;
    count_n         = count;
    filter_n        = filter;
    ifmap_n         = ifmap;
    filter_enable_n = 1'b0;
    ifmap_enable_n  = 1'b0;
    done_n          = 1'b0;
    reuse_n         = reuse_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
          count_n = '0;
`ifdef PE_FEEDER_FILTER_REUSE_EN
          reuse_n = reuse_filter;
          phase_n = reuse_filter ? IFMAP : FILTER;
`else
          reuse_n = 1'b0;
          phase_n = FILTER;
`endif
        end
      end

      LOAD: begin
        if (filter_in_ready && filter_in_valid) begin
          filter_n        = filter_in;
          filter_enable_n = 1'b1;
          phase_n         = IFMAP;
        end else if (ifmap_in_ready && ifmap_in_valid) begin
          ifmap_n        = ifmap_in;
          ifmap_enable_n = 1'b1;
          // In filter-reuse passes the phase never leaves IFMAP.
          phase_n        = reuse_q ? IFMAP : FILTER;
          if (count == LAST_IDX) begin
            count_n = '0;
            state_n = WAIT_PE;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end

      WAIT_PE: begin
        // pe_ready is not trusted while the last ifmap strobe is still on the bus.
        if (pe_ready && !ifmap_enable) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        phase_n = FILTER;
        count_n = '0;
      end
    endcase
  end

  // State, counter and output registers; reset discards any partial pass.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      phase         <= FILTER;
      count         <= '0;
      filter        <= '0;
      ifmap         <= '0;
      filter_enable <= 1'b0;
      ifmap_enable  <= 1'b0;
      done          <= 1'b0;
      reuse_q       <= 1'b0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      count         <= count_n;
      filter        <= filter_n;
      ifmap         <= ifmap_n;
      filter_enable <= filter_enable_n;
      ifmap_enable  <= ifmap_enable_n;
      done          <= done_n;
      reuse_q       <= reuse_n;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Testbench for pe_feeder (ROW_LEN=3, BITWIDTH=16).
// Strobe events are queued as {is_ifmap, data} when a handshake completes and
// are popped when the DUT raises filter_enable / ifmap_enable.
module tb_pe_feeder;
  import pe_pkg::*;

  localparam int BW = 16;
  localparam int RL = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic          filter_in_valid = 1'b0;
  logic [BW-1:0] filter_in = '0;
  logic          filter_in_ready;
  logic          ifmap_in_valid = 1'b0;
  logic [BW-1:0] ifmap_in = '0;
  logic          ifmap_in_ready;
  logic          pe_ready = 1'b0;
  logic          filter_enable;
  logic [BW-1:0] filter;
  logic          ifmap_enable;
  logic [BW-1:0] ifmap;
  logic          busy;
  logic          done;
  state_t        state_dbg;
`ifdef PE_FEEDER_FILTER_REUSE_EN
  logic          reuse_filter = 1'b0;
`endif

  always #5 clk = ~clk;

  pe_feeder #(.BITWIDTH(BW), .RF_ADDR_WIDTH(3), .ROW_LEN(RL)) dut (
    .clk             (clk),
    .rstb            (rstb),
    .start           (start),
`ifdef PE_FEEDER_FILTER_REUSE_EN
    .reuse_filter    (reuse_filter),
`endif
    .filter_in_valid (filter_in_valid),
    .filter_in       (filter_in),
    .filter_in_ready (filter_in_ready),
    .ifmap_in_valid  (ifmap_in_valid),
    .ifmap_in        (ifmap_in),
    .ifmap_in_ready  (ifmap_in_ready),
    .pe_ready        (pe_ready),
    .filter_enable   (filter_enable),
    .filter          (filter),
    .ifmap_enable    (ifmap_enable),
    .ifmap           (ifmap),
    .busy            (busy),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [BW:0]   exp_q[$];
  logic [BW-1:0] fw[RL];
  logic [BW-1:0] iw[RL];
  logic [BW-1:0] last_f = '0;
  logic [BW-1:0] last_i = '0;
  int            cyc = 0;
  int            strobe_cnt = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  int            fe_cnt = 0;
  int            ie_cnt = 0;
  int            done_cnt = 0;
  bit            abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop expected strobes, check data hold between strobes.
  always @(negedge clk) begin : monitor
    logic [BW:0] e;
    if (rstb) begin
      if (filter_enable && ifmap_enable) check("both_strobes", 1, 0);
      if (filter_enable || ifmap_enable) begin
        if (strobe_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        strobe_cnt++;
      end
      if (filter_enable) begin
        fe_cnt++;
        if (exp_q.size() == 0) check("f_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("f_strobe", {15'd0, 1'b0, filter}, {15'd0, e});
        end
        last_f = filter;
      end else begin
        check("f_hold", {16'd0, filter}, {16'd0, last_f});
      end
      if (ifmap_enable) begin
        ie_cnt++;
        if (exp_q.size() == 0) check("i_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("i_strobe", {15'd0, 1'b1, ifmap}, {15'd0, e});
        end
        last_i = ifmap;
      end else begin
        check("i_hold", {16'd0, ifmap}, {16'd0, last_i});
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_pass(input bit reuse);
    strobe_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
`ifdef PE_FEEDER_FILTER_REUSE_EN
    reuse_filter = reuse;
`else
    if (reuse) check("reuse_unsupported", 1, 0);
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic filter_source(input int stall_idx, input int stall_cycles);
    int g;
    for (int i = 0; i < RL; i++) begin
      if (abort) break;
      if (i == stall_idx) begin
        filter_in_valid = 1'b0;
        g = 0;
        for (int s = 0; s < stall_cycles && !abort && g < 200; g++) begin
          @(negedge clk);
          if (filter_in_ready) s++;
        end
        @(posedge clk); #1;
      end
      filter_in       = fw[i];
      filter_in_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!filter_in_ready && !abort && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (abort) break;
      if (!filter_in_ready) begin
        check("f_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      exp_q.push_back({1'b0, fw[i]});
      #1;
    end
    filter_in_valid = 1'b0;
  endtask

  task automatic ifmap_source();
    int g;
    for (int i = 0; i < RL; i++) begin
      if (abort) break;
      ifmap_in       = iw[i];
      ifmap_in_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!ifmap_in_ready && !abort && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (abort) break;
      if (!ifmap_in_ready) begin
        check("i_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      exp_q.push_back({1'b1, iw[i]});
      #1;
    end
    ifmap_in_valid = 1'b0;
  endtask

  // Called right after the last ifmap handshake; the next negedge is its strobe cycle.
  task automatic finish_pass(input bit early_ready);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    check("last_i_strobe", {31'd0, ifmap_enable}, 1);
    check("enter_wait_pe", {30'd0, state_dbg}, {30'd0, WAIT_PE});
    check("wait_pe_busy", {31'd0, busy}, 1);
    if (early_ready) begin
      @(negedge clk);
      check("early_no_done", {31'd0, done}, 0);
      check("early_busy", {31'd0, busy}, 1);
      @(negedge clk);
      check("early_done", {31'd0, done}, 1);
      check("early_idle", {31'd0, busy}, 0);
      pe_ready = 1'b0;
    end else begin
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("hold_no_done", {31'd0, done}, 0);
        check("hold_busy", {31'd0, busy}, 1);
      end
      @(posedge clk); #1;
      pe_ready = 1'b1;
      @(posedge clk); #1;
      pe_ready = 1'b0;
      start    = 1'b0;
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 1);
      check("busy_fall", {31'd0, busy}, 0);
    end
    @(negedge clk);
    check("done_single", {31'd0, done}, 0);
    check("start_ignored", {31'd0, busy}, 0);
    check("done_count", done_cnt - d0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_ie, g, fe0, d0;

    // Reset with upstream valids high: nothing may leak out.
    filter_in_valid = 1'b1;
    ifmap_in_valid  = 1'b1;
    filter_in       = 16'h1234;
    ifmap_in        = 16'h5678;
    repeat (2) @(negedge clk);
    check("rst_fen", {31'd0, filter_enable}, 0);
    check("rst_ien", {31'd0, ifmap_enable}, 0);
    check("rst_filter", {16'd0, filter}, 0);
    check("rst_ifmap", {16'd0, ifmap}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    rstb = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_fready", {31'd0, filter_in_ready}, 0);
      check("idle_iready", {31'd0, ifmap_in_ready}, 0);
      check("idle_fen", {31'd0, filter_enable}, 0);
    end
    filter_in_valid = 1'b0;
    ifmap_in_valid  = 1'b0;

    // Basic pass: F1,I1,F2,I2,F3,I3 on consecutive cycles.
    for (int i = 0; i < RL; i++) begin
      fw[i] = BW'(i + 1);
      iw[i] = BW'(i + 1);
    end
    start_pass(1'b0);
    fork
      filter_source(-1, 0);
      ifmap_source();
    join
    finish_pass(1'b0);
    check("basic_strobes", strobe_cnt, 2 * RL);
    check("basic_span", last_cyc - first_cyc, 2 * RL - 1);

    // Stall: filter valid dropped for 2 ready cycles before filter 2.
    for (int i = 0; i < RL; i++) begin
      fw[i] = BW'($urandom_range(0, 16'hFFFF));
      iw[i] = BW'($urandom_range(0, 16'hFFFF));
    end
    start_pass(1'b0);
    fork
      filter_source(1, 2);
      ifmap_source();
    join
    finish_pass(1'b0);
    check("stall_strobes", strobe_cnt, 2 * RL);
    check("stall_span", last_cyc - first_cyc, 2 * RL + 1);

    // pe_ready already high: ignored during the last ifmap strobe cycle.
    fw[0] = 16'h8000; fw[1] = 16'hFFFF; fw[2] = 16'h7FFF;
    iw[0] = 16'h8001; iw[1] = 16'h0000; iw[2] = 16'hFFFE;
    pe_ready = 1'b1;
    start_pass(1'b0);
    fork
      filter_source(-1, 0);
      ifmap_source();
    join
    finish_pass(1'b1);

    // Asynchronous reset after I2: immediate clear, no done.
    for (int i = 0; i < RL; i++) begin
      fw[i] = BW'(16'h0A00 + i);
      iw[i] = BW'(16'h0B00 + i);
    end
    base_ie = ie_cnt;
    d0      = done_cnt;
    start_pass(1'b0);
    fork
      filter_source(-1, 0);
      ifmap_source();
      begin
        g = 0;
        while (ie_cnt < base_ie + 2 && g < 200) begin
          @(negedge clk);
          g++;
        end
        check("reach_i2", ie_cnt - base_ie, 2);
        #2;
        abort = 1'b1;
        rstb  = 1'b0;
        #1;
        check("mid_rst_fen", {31'd0, filter_enable}, 0);
        check("mid_rst_ien", {31'd0, ifmap_enable}, 0);
        check("mid_rst_filter", {16'd0, filter}, 0);
        check("mid_rst_ifmap", {16'd0, ifmap}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
      end
    join
    exp_q.delete();
    last_f = '0;
    last_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rstb  = 1'b1;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_idle", {31'd0, busy}, 0);

    // Fresh pass after reset reloads from F1.
    start_pass(1'b0);
    fork
      filter_source(-1, 0);
      ifmap_source();
    join
    finish_pass(1'b0);
    check("reload_strobes", strobe_cnt, 2 * RL);
    check("reload_span", last_cyc - first_cyc, 2 * RL - 1);

`ifdef PE_FEEDER_FILTER_REUSE_EN
    // Filter reuse: ifmap-only pass with back-to-back strobes.
    iw[0] = 16'd4; iw[1] = 16'd5; iw[2] = 16'd6;
    fe0 = fe_cnt;
    start_pass(1'b1);
    ifmap_source();
    finish_pass(1'b0);
    check("reuse_no_fen", fe_cnt - fe0, 0);
    check("reuse_strobes", strobe_cnt, RL);
    check("reuse_span", last_cyc - first_cyc, RL - 1);
    reuse_filter = 1'b0;
`else
    fe0 = fe_cnt;
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
